// File: rtl/signal_gen_param.sv
// ---------------------------------------------------------------------------
// signal_gen_param
//
// Parametrised QPSK signal generator. Packed message bytes are read from an
// external message RAM and unpacked into 2-bit symbols, MSB pair first. Each
// symbol becomes signed I/Q levels (bit1 -> I, bit0 -> Q; 0 -> +AMP,
// 1 -> -AMP). Each symbol is emitted as OSR samples on a valid/ready stream.
//
// Sample modes (latched on start):
//   mode 0 : hold        - every phase of a symbol carries the mapped level
//   mode 1 : zero-stuff  - phase 0 carries the level, phases 1..OSR-1 carry 0
//
// Optional build feature:
//   SIGNAL_GEN_PREAMBLE_EN - adds parameter PREAMBLE_LEN and a PREAMBLE state.
//   That state emits PREAMBLE_LEN alternating 00/11 symbols ahead of the
//   message on every start with a non-zero length.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   enable       start strobe, honoured only in IDLE
//   msg_length   message length in symbols, latched on start
//   mode         sample mode, latched on start
//   ram_data     RAM read data, valid the cycle after read_enable
//   ram_addr     RAM byte address
//   read_enable  RAM read strobe, one cycle per byte
//   out_i/out_q  registered signed I/Q samples
//   out_valid    sample valid, held until out_ready accepts it
//   out_ready    downstream accept
//   busy         high in every state except IDLE
//   done         one-cycle pulse at end of message
// ---------------------------------------------------------------------------
module signal_gen_param #(
  parameter int ADDR_W   = 10,
  parameter int LEN_W    = 16,
  parameter int SAMPLE_W = 13,
  parameter int OSR      = 8,     // power of two, 2..32
  parameter int AMP      = 2047   // must fit in SAMPLE_W-1 bits
`ifdef SIGNAL_GEN_PREAMBLE_EN
  ,
  parameter int PREAMBLE_LEN = 16
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [LEN_W-1:0]           msg_length,
  input  logic                       mode,
  input  logic [7:0]                 ram_data,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic                       read_enable,
  output logic signed [SAMPLE_W-1:0] out_i,
  output logic signed [SAMPLE_W-1:0] out_q,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int PH_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);

  localparam logic signed [SAMPLE_W-1:0] LVL_POS = SAMPLE_W'(AMP);
  localparam logic signed [SAMPLE_W-1:0] LVL_NEG = -LVL_POS;

`ifdef SIGNAL_GEN_PREAMBLE_EN
  localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_LEN - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EMIT,
    S_DONE
`ifdef SIGNAL_GEN_PREAMBLE_EN
    ,
    S_PREAMBLE
`endif
  } state_e;

  // Symbol bit to signed level: 0 -> +AMP, 1 -> -AMP.
  function automatic logic signed [SAMPLE_W-1:0] level(input logic b);
    return b ? LVL_NEG : LVL_POS;
  endfunction

  // Slot 0 is the most significant bit pair of the byte.
  function automatic logic [1:0] pick_sym(input logic [7:0] b, input logic [1:0] s);
    logic [1:0] r;
    case (s)
      2'd0:    r = b[7:6];
      2'd1:    r = b[5:4];
      2'd2:    r = b[3:2];
      default: r = b[1:0];
    endcase
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e                       state_q,     state_d;
  logic [ADDR_W-1:0]            ram_addr_q,  ram_addr_d;
  logic [7:0]                   byte_q,      byte_d;
  logic [1:0]                   slot_q,      slot_d;
  logic [PH_W-1:0]              phase_q,     phase_d;
  logic [LEN_W-1:0]             sym_cnt_q,   sym_cnt_d;
  logic [LEN_W-1:0]             len_q,       len_d;
  logic                         mode_q,      mode_d;
  logic signed [SAMPLE_W-1:0]   out_i_q,     out_i_d;
  logic signed [SAMPLE_W-1:0]   out_q_q,     out_q_d;
  logic                         out_valid_q, out_valid_d;
`ifdef SIGNAL_GEN_PREAMBLE_EN
  logic [PRE_W-1:0]             pre_cnt_q,   pre_cnt_d;
`endif

  // -------------------------------------------------------------------------
  // Helpers shared by the next-state logic
  // -------------------------------------------------------------------------
  logic             fire;
  logic [1:0]       cur_sym;
  logic [1:0]       nxt_sym;
  logic [LEN_W-1:0] sym_next;

  assign fire     = out_valid_q & out_ready;
  assign cur_sym  = pick_sym(byte_q, slot_q);
  assign nxt_sym  = pick_sym(byte_q, slot_q + 2'd1);
  assign sym_next = sym_cnt_q + LEN_W'(1);

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d signal gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    byte_d      = byte_q;
    slot_d      = slot_q;
    phase_d     = phase_q;
    sym_cnt_d   = sym_cnt_q;
    len_d       = len_q;
    mode_d      = mode_q;
    out_i_d     = out_i_q;
    out_q_d     = out_q_q;
    out_valid_d = out_valid_q;
`ifdef SIGNAL_GEN_PREAMBLE_EN
    pre_cnt_d   = pre_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          len_d      = msg_length;
          mode_d     = mode;
          ram_addr_d = '0;
          sym_cnt_d  = '0;
          phase_d    = '0;
          slot_d     = '0;
          if (msg_length == '0) begin
            state_d = S_DONE;
          end else begin
`ifdef SIGNAL_GEN_PREAMBLE_EN
            // The first preamble symbol is 00, so it is presented immediately.
            state_d     = S_PREAMBLE;
            pre_cnt_d   = '0;
            out_valid_d = 1'b1;
            out_i_d     = LVL_POS;
            out_q_d     = LVL_POS;
`else
            state_d = S_FETCH;
`endif
          end
        end
      end

      S_FETCH: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // The RAM answers now. Phase 0 of slot 0 is loaded straight from
        // ram_data so the first sample is valid in the very next cycle.
        byte_d      = ram_data;
        slot_d      = '0;
        phase_d     = '0;
        out_valid_d = 1'b1;
        out_i_d     = level(ram_data[7]);
        out_q_d     = level(ram_data[6]);
        state_d     = S_EMIT;
      end

      S_EMIT: begin
        if (fire) begin
          if (phase_q != PH_LAST) begin
            phase_d = phase_q + PH_W'(1);
            out_i_d = mode_q ? '0 : level(cur_sym[1]);
            out_q_d = mode_q ? '0 : level(cur_sym[0]);
          end else begin
            phase_d   = '0;
            sym_cnt_d = sym_next;
            if (sym_next == len_q) begin
              // Any unused symbols left in a partial final byte are dropped.
              state_d     = S_DONE;
              out_valid_d = 1'b0;
              out_i_d     = '0;
              out_q_d     = '0;
            end else if (slot_q == 2'd3) begin
              // ram_addr wraps naturally at 2^ADDR_W.
              ram_addr_d  = ram_addr_q + ADDR_W'(1);
              state_d     = S_FETCH;
              out_valid_d = 1'b0;
              out_i_d     = '0;
              out_q_d     = '0;
            end else begin
              slot_d  = slot_q + 2'd1;
              out_i_d = level(nxt_sym[1]);
              out_q_d = level(nxt_sym[0]);
            end
          end
        end
      end

`ifdef SIGNAL_GEN_PREAMBLE_EN
      S_PREAMBLE: begin
        // Even preamble symbols are 00 and odd ones are 11, so both I and Q
        // follow pre_cnt_q[0].
        if (fire) begin
          if (phase_q != PH_LAST) begin
            phase_d = phase_q + PH_W'(1);
            out_i_d = mode_q ? '0 : level(pre_cnt_q[0]);
            out_q_d = mode_q ? '0 : level(pre_cnt_q[0]);
          end else begin
            phase_d = '0;
            if (pre_cnt_q == PRE_LAST) begin
              state_d     = S_FETCH;
              out_valid_d = 1'b0;
              out_i_d     = '0;
              out_q_d     = '0;
            end else begin
              pre_cnt_d = pre_cnt_q + PRE_W'(1);
              out_i_d   = level(~pre_cnt_q[0]);
              out_q_d   = level(~pre_cnt_q[0]);
            end
          end
        end
      end
`endif

      S_DONE: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ram_addr_q  <= '0;
      byte_q      <= '0;
      slot_q      <= '0;
      phase_q     <= '0;
      sym_cnt_q   <= '0;
      len_q       <= '0;
      mode_q      <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      out_valid_q <= 1'b0;
`ifdef SIGNAL_GEN_PREAMBLE_EN
      pre_cnt_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every register sample its _d value
      // from the same clock edge, independent of statement order.
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      byte_q      <= byte_d;
      slot_q      <= slot_d;
      phase_q     <= phase_d;
      sym_cnt_q   <= sym_cnt_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
      out_valid_q <= out_valid_d;
`ifdef SIGNAL_GEN_PREAMBLE_EN
      pre_cnt_q   <= pre_cnt_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign ram_addr    = ram_addr_q;
  assign read_enable = (state_q == S_FETCH);
  assign out_i       = out_i_q;
  assign out_q       = out_q_q;
  assign out_valid   = out_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_signal_gen_param.sv
// ---------------------------------------------------------------------------
// tb_signal_gen_param
//
// Directed bench for signal_gen_param with a behavioural message RAM. When a
// start is issued, the expected I/Q stream is pushed into a queue. A monitor
// pops one entry on every out_valid && out_ready handshake and compares it.
// The RAM model also logs every read address. Compile with
// SIGNAL_GEN_PREAMBLE_EN defined to exercise the preamble build.
// ---------------------------------------------------------------------------
module tb_signal_gen_param;

  localparam int ADDR_W   = 10;
  localparam int LEN_W    = 16;
  localparam int SAMPLE_W = 13;
  localparam int OSR      = 8;
  localparam int AMP      = 2047;

`ifdef SIGNAL_GEN_PREAMBLE_EN
  localparam int PRE_SYMS = 16;
`else
  localparam int PRE_SYMS = 0;
`endif
  // Extra cycles the preamble adds in front of the first RAM fetch.
  localparam int P         = PRE_SYMS * OSR;
  // Cycle of the first out_valid after the start edge.
  localparam int FIRST_VAL = (PRE_SYMS != 0) ? 1 : 3;

  logic                       clk;
  logic                       reset;
  logic                       enable;
  logic [LEN_W-1:0]           msg_length;
  logic                       mode;
  logic [7:0]                 ram_data;
  logic [ADDR_W-1:0]          ram_addr;
  logic                       read_enable;
  logic signed [SAMPLE_W-1:0] out_i;
  logic signed [SAMPLE_W-1:0] out_q;
  logic                       out_valid;
  logic                       out_ready;
  logic                       busy;
  logic                       done;

  signal_gen_param #(
    .ADDR_W  (ADDR_W),
    .LEN_W   (LEN_W),
    .SAMPLE_W(SAMPLE_W),
    .OSR     (OSR),
    .AMP     (AMP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .msg_length (msg_length),
    .mode       (mode),
    .ram_data   (ram_data),
    .ram_addr   (ram_addr),
    .read_enable(read_enable),
    .out_i      (out_i),
    .out_q      (out_q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Bookkeeping
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int i;
    int q;
  } samp_t;

  samp_t exp_q[$];
  int    rd_log[$];
  logic [7:0] mem [0:(1<<ADDR_W)-1];

  // -------------------------------------------------------------------------
  // Message RAM: data appears the cycle after read_enable
  // -------------------------------------------------------------------------
  always @(posedge clk) begin
    if (!reset && read_enable) begin
      ram_data <= mem[ram_addr];
      rd_log.push_back(int'(ram_addr));
    end
  end

  // -------------------------------------------------------------------------
  // Reference model: expected sample stream for one start
  // -------------------------------------------------------------------------
  task automatic push_symbol(input logic [1:0] sym, input bit md);
    samp_t s;
    for (int p = 0; p < OSR; p++) begin
      s.i = (md && p != 0) ? 0 : (sym[1] ? -AMP : AMP);
      s.q = (md && p != 0) ? 0 : (sym[0] ? -AMP : AMP);
      exp_q.push_back(s);
    end
  endtask

  task automatic model_msg(input int len, input bit md);
    logic [7:0] b;
    if (len != 0) begin
      for (int k = 0; k < PRE_SYMS; k++) push_symbol((k % 2 == 1) ? 2'b11 : 2'b00, md);
    end
    for (int s = 0; s < len; s++) begin
      b = mem[s / 4];
      push_symbol(2'((b >> (6 - 2 * (s % 4))) & 8'h03), md);
    end
  endtask

  // -------------------------------------------------------------------------
  // Output monitor: scoreboard pops and stall-stability checks
  // -------------------------------------------------------------------------
  logic  prev_stall = 1'b0;
  int    prev_i     = 0;
  int    prev_q     = 0;
  samp_t got_e;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_i", $signed(out_i), prev_i);
        check("stall_q", $signed(out_q), prev_q);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_sample", int'(out_valid), 0);
        end else begin
          got_e = exp_q.pop_front();
          check("sample_i", $signed(out_i), got_e.i);
          check("sample_q", $signed(out_q), got_e.q);
        end
      end
      prev_stall <= out_valid && !out_ready;
      prev_i     <= $signed(out_i);
      prev_q     <= $signed(out_q);
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a message and steps cycle by cycle until done (bounded). Cycle 1
  // is the first cycle after the start edge. out_ready is dropped for five
  // cycles starting at stall_at, and a stray enable is pulsed at poke_at.
  task automatic run_msg(input string tag, input int len, input bit md,
                         input int stall_at, input int poke_at,
                         output int first_rd, output int first_val,
                         output int done_cyc);
    int c;
    rd_log.delete();
    model_msg(len, md);
    enable     = 1'b1;
    msg_length = LEN_W'(len);
    mode       = md;
    tick();
    // Change the inputs after the start so that latching is exercised.
    enable     = 1'b0;
    msg_length = '1;
    mode       = ~md;
    first_rd   = -1;
    first_val  = -1;
    done_cyc   = -1;
    c          = 1;
    while (c < 2000) begin
      out_ready = !(stall_at >= 0 && c >= stall_at && c < stall_at + 5);
      enable    = (c == poke_at);
      if (c == poke_at) msg_length = LEN_W'(1);
      if (read_enable && first_rd < 0) first_rd = c;
      if (out_valid && first_val < 0) first_val = c;
      if (done) begin
        done_cyc = c;
        check({tag, "_valid_at_done"}, int'(out_valid), 0);
        break;
      end
      tick();
      c++;
    end
    out_ready = 1'b1;
    enable    = 1'b0;
    tick();
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_idle"}, int'(busy), 0);
    check({tag, "_samples_left"}, exp_q.size(), 0);
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  int fr, fv, dc;

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 8'h00;
    reset      = 1'b1;
    enable     = 1'b0;
    msg_length = '0;
    mode       = 1'b0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", int'(ram_addr), 0);
    check("rst_rd", int'(read_enable), 0);
    check("rst_i", $signed(out_i), 0);
    check("rst_q", $signed(out_q), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    reset = 1'b0;
    tick();

    // Basic run: four symbols 00,01,10,11 in hold mode
    mem[0] = 8'b00_01_10_11;
    run_msg("basic", 4, 1'b0, -1, -1, fr, fv, dc);
    check("basic_first_read", fr, 1 + P);
    check("basic_first_valid", fv, FIRST_VAL);
    check("basic_done_cycle", dc, 35 + P);
    check("basic_reads", rd_log.size(), 1);

    // Zero-stuff over two bytes, with a stray enable while busy
    mem[0] = 8'h00;
    mem[1] = 8'hC0;
    run_msg("zstuff", 5, 1'b1, -1, 10, fr, fv, dc);
    check("zstuff_first_read", fr, 1 + P);
    check("zstuff_done_cycle", dc, 45 + P);
    check("zstuff_reads", rd_log.size(), 2);
    check("zstuff_addr0", (rd_log.size() > 0) ? rd_log[0] : -1, 0);
    check("zstuff_addr1", (rd_log.size() > 1) ? rd_log[1] : -1, 1);

    // Backpressure: five stalled cycles in the middle of a symbol
    mem[0] = 8'h9C;
    run_msg("bp", 4, 1'b0, 6, -1, fr, fv, dc);
    check("bp_first_valid", fv, FIRST_VAL);
    check("bp_done_cycle", dc, 40 + P);

    // Zero length: done right away, no fetch, no samples
    run_msg("zero", 0, 1'b0, -1, -1, fr, fv, dc);
    check("zero_first_read", fr, -1);
    check("zero_first_valid", fv, -1);
    check("zero_done_cycle", dc, 1);
    check("zero_reads", rd_log.size(), 0);

    // Reset during EMIT of the second byte
    mem[0] = 8'h1B;
    mem[1] = 8'h72;
    model_msg(8, 1'b0);
    enable     = 1'b1;
    msg_length = LEN_W'(8);
    mode       = 1'b0;
    tick();
    enable = 1'b0;
    repeat (39 + P) tick();
    check("mid_addr", int'(ram_addr), 1);
    check("mid_busy", int'(busy), 1);
    check("mid_valid", int'(out_valid), 1);
    #2 reset = 1'b1;
    #1;
    check("async_addr", int'(ram_addr), 0);
    check("async_rd", int'(read_enable), 0);
    check("async_i", $signed(out_i), 0);
    check("async_q", $signed(out_q), 0);
    check("async_valid", int'(out_valid), 0);
    check("async_busy", int'(busy), 0);
    check("async_done", int'(done), 0);
    exp_q.delete();
    @(posedge clk);
    #3 reset = 1'b0;
    tick();
    check("post_rst_busy", int'(busy), 0);

    // Restart after reset begins again at address 0
    mem[0] = 8'hE4;
    run_msg("restart", 4, 1'b0, -1, -1, fr, fv, dc);
    check("restart_first_read", fr, 1 + P);
    check("restart_addr0", (rd_log.size() > 0) ? rd_log[0] : -1, 0);
    check("restart_done_cycle", dc, 35 + P);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/signal_gen_param.md
Name: signal_gen_param

Overview:
- Parametrised successor to the fixed QPSK signal generator.
- Fetches packed message bytes from the message RAM and unpacks them into 2-bit QPSK symbols.
- Maps each symbol to signed I/Q levels and emits OSR samples per symbol.
- Samples go out on a valid/ready stream to the downstream pulse-shaping filter or DAC path. Message length is a run-time input; output supports backpressure and two sample modes.

Parameters:
- ADDR_W, 10, RAM address width.
- LEN_W, 16, width of the message-length input, in symbols.
- SAMPLE_W, 13, signed I/Q sample width.
- OSR, 8, samples per symbol; power of two, 2..32.
- AMP, 2047, positive mapping level; must fit in SAMPLE_W-1 bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- enable  in  1  start strobe; sampled in IDLE only.
- msg_length  in  LEN_W  symbol count; latched on start.
- mode  in  1  0 = hold (rectangular), 1 = zero-stuff; latched on start.
- ram_data  in  8  RAM read data; valid one cycle after read_enable.
- ram_addr  out  ADDR_W  RAM byte address.
- read_enable  out  1  RAM read strobe.
- out_i  out  SAMPLE_W  signed I sample.
- out_q  out  SAMPLE_W  signed Q sample.
- out_valid  out  1  sample valid.
- out_ready  in  1  downstream accept.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at end of message.

Behaviour:
- Reset (async, any time, including mid-message):
  - state = IDLE.
  - ram_addr, out_i, out_q = 0.
  - read_enable, out_valid, busy, done = 0.
  - Symbol counter and phase counter cleared.
- States: IDLE, FETCH, WAIT, EMIT, DONE.
- IDLE:
  - If enable: latch msg_length and mode, set ram_addr = 0.
  - If msg_length == 0, go to DONE; otherwise go to FETCH.
  - enable is ignored outside IDLE.
- FETCH: read_enable = 1 for exactly this cycle with the current ram_addr; go to WAIT.
- WAIT: capture ram_data into the byte register at the end of the cycle; set slot = 0; go to EMIT.
- EMIT:
  - Current symbol is byte[7-2*slot : 6-2*slot], MSB pair first.
  - Symbol bit1 drives I, bit0 drives Q; 0 maps to +AMP, 1 maps to -AMP (two's complement).
  - out_valid = 1. Sample advances only on a cycle where out_valid && out_ready.
  - out_i, out_q and out_valid are registered and stay stable while out_ready = 0.
  - Phase counter runs 0..OSR-1.
  - mode 0: every phase carries the mapped value.
  - mode 1: phase 0 carries the mapped value; phases 1..OSR-1 carry 0.
  - On the handshake of phase OSR-1, increment the symbol count:
    - count == msg_length: go to DONE.
    - Else if slot == 3: ram_addr += 1, go to FETCH.
    - Else: slot += 1, stay in EMIT.
- DONE: done = 1 for one cycle; out_valid = 0; go to IDLE.
- Latency: with enable high at edge 0, read_enable is high in cycle 1 and the first out_valid is in cycle 3.
- Steady state: the FETCH/WAIT gap costs 2 bubble cycles per 4 symbols.
- A partial final byte's unused symbols are discarded.
- ram_addr wraps modulo 2^ADDR_W.
- A simultaneous enable and reset resolves to reset.

Optional Feature:
- Macro: SIGNAL_GEN_PREAMBLE_EN.
- Defined:
  - Adds parameter PREAMBLE_LEN (default 16) and state PREAMBLE, entered from IDLE on a start with msg_length != 0.
  - PREAMBLE emits PREAMBLE_LEN symbols alternating 2'b00, 2'b11 (starting 00), each OSR samples, with the same mode and handshake rules.
  - After the last preamble sample handshake, go to FETCH.
  - A start with msg_length == 0 still goes straight to DONE.
- Undefined: no PREAMBLE state; behaviour exactly as above.

Test Plan:
- Basic run:
  - Setup: OSR=8, mode 0, out_ready=1, msg_length=4, RAM[0]=8'b00_01_10_11, pulse enable.
  - Expected: read_enable in cycle 1; 32 valid samples from cycle 3; I/Q = (+2047,+2047)x8, (+2047,-2047)x8, (-2047,+2047)x8, (-2047,-2047)x8; done one cycle after the last sample.
- Zero-stuff and multi-byte:
  - Setup: mode 1, msg_length=5, RAM[0]=8'h00, RAM[1]=8'hC0.
  - Expected: 40 samples; nonzero only at phase 0; symbol 5 = (-2047,-2047); exactly two reads, addresses 0 then 1; remaining symbols of byte 1 discarded.
- Backpressure:
  - Setup: drop out_ready for 5 cycles mid-symbol.
  - Expected: out_valid, out_i and out_q stay constant; no phase advances; total sample count unchanged.
- Zero length and restart:
  - Setup: msg_length=0, pulse enable.
  - Expected: done 1 cycle later, no read_enable, no out_valid.
  - Also: enable asserted while busy is ignored.
- Reset mid-message:
  - Setup: assert reset asynchronously during EMIT.
  - Expected: all outputs 0 immediately; after release a new start begins at ram_addr=0.
- Preamble (SIGNAL_GEN_PREAMBLE_EN defined):
  - Setup: PREAMBLE_LEN=16, msg_length=4.
  - Expected: 128 preamble samples alternating (+,+)/(-,-) precede the data; first read_enable comes after the preamble.
